// File: rtl/ddr3_dqsw_write_leveling_ctrl.sv
// Write-leveling sweep controller for one DDR3 lane's DQSW training IOD.
// Optional define DQSW_EYE_FLAG_CAPTURE_EN adds eye-monitor flag capture on the result tap.
module ddr3_dqsw_write_leveling_ctrl #(
   parameter int TAP_W         = 8,
   parameter int MAX_TAPS      = 128,
   parameter int SETTLE_CYCLES = 16,
   parameter int SAMPLES       = 8
) (
   input  logic             FAB_CLK,
   input  logic             RESET_N,
   input  logic             START,
   output logic             BUSY,
   output logic             DONE,
   output logic             ERROR,
   output logic [TAP_W-1:0] TAP_COUNT,
   output logic             DELAY_LINE_LOAD,
   output logic             DELAY_LINE_MOVE,
   output logic             DELAY_LINE_DIRECTION,
   output logic             EYE_MONITOR_CLEAR_FLAGS,
`ifdef DQSW_EYE_FLAG_CAPTURE_EN
   input  logic             EYE_MONITOR_EARLY,
   input  logic             EYE_MONITOR_LATE,
   output logic [1:0]       EYE_FLAGS,
`endif
   input  logic             DELAY_LINE_OUT_OF_RANGE,
   input  logic [1:0]       RX_DATA
);

   localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int ONES_W  = $clog2(SAMPLES + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_SETTLE, S_SAMPLE, S_DECIDE, S_STEP, S_DONE, S_FAIL
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [ONES_W-1:0] ones;
   logic [TAP_W-1:0]  tap;
   logic              seen_zero;
   logic              maj;
   logic              tap_last;
   logic              rx_hit;

   // Strict majority: a tie counts as a 0 vote.
   assign maj      = ({ones, 1'b0} > (ONES_W+1)'(SAMPLES));
   assign tap_last = (tap == TAP_W'(MAX_TAPS - 1));
   assign rx_hit   = (RX_DATA == 2'b11);

   always_ff @(posedge FAB_CLK) begin
      if (!RESET_N) begin
         state                   <= S_IDLE;
         cnt                     <= '0;
         ones                    <= '0;
         tap                     <= '0;
         seen_zero               <= 1'b0;
         BUSY                    <= 1'b0;
         DONE                    <= 1'b0;
         ERROR                   <= 1'b0;
         TAP_COUNT               <= '0;
         DELAY_LINE_LOAD         <= 1'b0;
         DELAY_LINE_MOVE         <= 1'b0;
         DELAY_LINE_DIRECTION    <= 1'b0;
         EYE_MONITOR_CLEAR_FLAGS <= 1'b0;
`ifdef DQSW_EYE_FLAG_CAPTURE_EN
         EYE_FLAGS               <= 2'b00;
`endif
      end else begin
         DELAY_LINE_LOAD         <= 1'b0;
         DELAY_LINE_MOVE         <= 1'b0;
         DELAY_LINE_DIRECTION    <= 1'b0;
         EYE_MONITOR_CLEAR_FLAGS <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_FAIL: begin
               if (START) begin
                  state                   <= S_LOAD;
                  BUSY                    <= 1'b1;
                  DONE                    <= 1'b0;
                  ERROR                   <= 1'b0;
                  tap                     <= '0;
                  TAP_COUNT               <= '0;
                  seen_zero               <= 1'b0;
                  DELAY_LINE_LOAD         <= 1'b1;
                  EYE_MONITOR_CLEAR_FLAGS <= 1'b1;
`ifdef DQSW_EYE_FLAG_CAPTURE_EN
                  EYE_FLAGS               <= 2'b00;
`endif
               end
            end
            S_LOAD, S_STEP: begin
               if (state == S_STEP) begin
                  tap       <= tap + TAP_W'(1);
                  TAP_COUNT <= tap + TAP_W'(1);
               end
               cnt   <= '0;
               state <= S_SETTLE;
            end
            S_SETTLE: begin
               if (DELAY_LINE_OUT_OF_RANGE) begin
                  state     <= S_FAIL;
                  BUSY      <= 1'b0;
                  ERROR     <= 1'b1;
                  TAP_COUNT <= tap;
               end else if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                  state <= S_SAMPLE;
                  cnt   <= '0;
                  ones  <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_SAMPLE: begin
               ones <= ones + ONES_W'(rx_hit);
`ifdef DQSW_EYE_FLAG_CAPTURE_EN
               EYE_FLAGS <= EYE_FLAGS | {EYE_MONITOR_LATE, EYE_MONITOR_EARLY};
`endif
               if (cnt == CNT_W'(SAMPLES - 1)) begin
                  state <= S_DECIDE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_DECIDE: begin
               if (maj && seen_zero) begin
                  state     <= S_DONE;
                  BUSY      <= 1'b0;
                  DONE      <= 1'b1;
                  TAP_COUNT <= tap;
               end else begin
                  if (!maj) seen_zero <= 1'b1;
                  if (tap_last) begin
                     state     <= S_FAIL;
                     BUSY      <= 1'b0;
                     ERROR     <= 1'b1;
                     TAP_COUNT <= tap;
                  end else begin
                     state                   <= S_STEP;
                     DELAY_LINE_MOVE         <= 1'b1;
                     DELAY_LINE_DIRECTION    <= 1'b1;
                     EYE_MONITOR_CLEAR_FLAGS <= 1'b1;
`ifdef DQSW_EYE_FLAG_CAPTURE_EN
                     EYE_FLAGS               <= 2'b00;
`endif
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ddr3_dqsw_write_leveling_ctrl.sv
// Bench for the DQSW write-leveling controller: vector table, reset corner case, random sweeps.
module tb_ddr3_dqsw_write_leveling_ctrl;

   localparam int TW      = 8;
   localparam int NTAP    = 16;
   localparam int SETTLE  = 16;
   localparam int NSMP    = 8;
   localparam int TAP_CYC = SETTLE + NSMP + 2;
   localparam int BUDGET  = NTAP * TAP_CYC + 60;

   logic          FAB_CLK = 1'b0;
   logic          RESET_N = 1'b0;
   logic          START = 1'b0;
   logic          BUSY, DONE, ERROR;
   logic [TW-1:0] TAP_COUNT;
   logic          DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS;
   logic          DELAY_LINE_OUT_OF_RANGE = 1'b0;
   logic [1:0]    RX_DATA = 2'b00;

   ddr3_dqsw_write_leveling_ctrl #(
      .TAP_W(TW), .MAX_TAPS(NTAP), .SETTLE_CYCLES(SETTLE), .SAMPLES(NSMP)
   ) dut (
      .FAB_CLK(FAB_CLK), .RESET_N(RESET_N), .START(START),
      .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .TAP_COUNT(TAP_COUNT),
      .DELAY_LINE_LOAD(DELAY_LINE_LOAD), .DELAY_LINE_MOVE(DELAY_LINE_MOVE),
      .DELAY_LINE_DIRECTION(DELAY_LINE_DIRECTION),
      .EYE_MONITOR_CLEAR_FLAGS(EYE_MONITOR_CLEAR_FLAGS),
      .DELAY_LINE_OUT_OF_RANGE(DELAY_LINE_OUT_OF_RANGE), .RX_DATA(RX_DATA)
   );

   always #5 FAB_CLK = ~FAB_CLK;

   typedef struct {
      string                  name;
      logic [NTAP-1:0][7:0]   mask;   // per tap: which of the 8 samples return 11
      int                     oor_tap;
      bit                     exp_done;
      bit                     exp_err;
      int                     exp_tap;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;

   logic [NTAP-1:0][7:0] cur_mask = '0;
   int oor_tap = 99;
   localparam int OOR_OFF = 2;

   int drv_tap = 0, drv_off = 0;
   int load_cnt = 0, move_cnt = 0, viol = 0;
   logic [1:0] mixed [3] = '{2'b00, 2'b01, 2'b10};

   // Environment: follows LOAD/MOVE pulses to know which tap/window the IOD is in.
   always @(posedge FAB_CLK) begin
      int j;
      #1;
      if (DELAY_LINE_LOAD) begin
         drv_tap = 0; drv_off = 0; load_cnt++;
      end else if (DELAY_LINE_MOVE) begin
         drv_tap++; drv_off = 0; move_cnt++;
      end else begin
         drv_off++;
      end
      if (DELAY_LINE_DIRECTION != DELAY_LINE_MOVE) viol++;
      if (EYE_MONITOR_CLEAR_FLAGS != (DELAY_LINE_LOAD | DELAY_LINE_MOVE)) viol++;
      if (BUSY && (DONE || ERROR)) viol++;
      j = drv_off - SETTLE - 1;
      if (j >= 0 && j < NSMP && drv_tap < NTAP)
         RX_DATA = cur_mask[drv_tap][j] ? 2'b11 : mixed[$urandom % 3];
      else
         RX_DATA = 2'($urandom);
      DELAY_LINE_OUT_OF_RANGE = (drv_tap == oor_tap) && (drv_off == OOR_OFF);
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string nm);
      chk({nm, " BUSY"}, BUSY, 0);
      chk({nm, " DONE"}, DONE, 0);
      chk({nm, " ERROR"}, ERROR, 0);
      chk({nm, " TAP_COUNT"}, TAP_COUNT, 0);
      chk({nm, " LOAD"}, DELAY_LINE_LOAD, 0);
      chk({nm, " MOVE"}, DELAY_LINE_MOVE, 0);
      chk({nm, " DIR"}, DELAY_LINE_DIRECTION, 0);
      chk({nm, " CLR"}, EYE_MONITOR_CLEAR_FLAGS, 0);
   endtask

   // Reference: first tap whose majority is 1 after at least one majority-0 tap.
   function automatic void model(input logic [NTAP-1:0][7:0] m,
                                 output bit d, output bit e, output int t);
      bit seen = 0;
      d = 0; e = 0; t = 0;
      for (int k = 0; k < NTAP; k++) begin
         bit b = ($countones(m[k]) * 2 > NSMP);
         if (b && seen) begin d = 1; t = k; return; end
         if (!b) seen = 1;
         if (k == NTAP - 1) begin e = 1; t = k; end
      end
   endfunction

   function automatic vec_t mk(input string nm, input logic [NTAP-1:0][7:0] m,
                               input int ot, input bit d, input bit e, input int t);
      vec_t v;
      v.name = nm; v.mask = m; v.oor_tap = ot;
      v.exp_done = d; v.exp_err = e; v.exp_tap = t;
      return v;
   endfunction

   task automatic run_case(input vec_t v);
      int l0, m0, v0, cyc, elat;
      bit fin;
      cur_mask = v.mask;
      oor_tap  = v.oor_tap;
      elat = (v.oor_tap < NTAP) ? v.oor_tap * TAP_CYC + OOR_OFF + 1 : (v.exp_tap + 1) * TAP_CYC;
      l0 = load_cnt; m0 = move_cnt; v0 = viol;
      @(negedge FAB_CLK); START = 1'b1;
      @(posedge FAB_CLK); #2; START = 1'b0;
      cyc = 0; fin = 0;
      while (!fin && cyc < BUDGET) begin
         @(posedge FAB_CLK); #2; cyc++;
         START = (cyc == 40);   // must be ignored mid-sweep
         if (DONE || ERROR) fin = 1;
      end
      START = 1'b0;
      chk({v.name, " finished"}, fin, 1);
      chk({v.name, " DONE"}, DONE, v.exp_done);
      chk({v.name, " ERROR"}, ERROR, v.exp_err);
      chk({v.name, " TAP_COUNT"}, TAP_COUNT, v.exp_tap);
      chk({v.name, " BUSY"}, BUSY, 0);
      chk({v.name, " moves"}, move_cnt - m0, v.exp_tap);
      chk({v.name, " loads"}, load_cnt - l0, 1);
      chk({v.name, " latency"}, cyc, elat);
      chk({v.name, " pulse rules"}, viol - v0, 0);
      repeat (3) @(posedge FAB_CLK);
      #2;
      chk({v.name, " held"}, {DONE, ERROR, TAP_COUNT}, {v.exp_done, v.exp_err, 8'(v.exp_tap)});
   endtask

   vec_t tv [7];

   initial begin
      logic [NTAP-1:0][7:0] m;
      bit d, e;
      int t, waited;

      m = '0; for (int k = 5; k < NTAP; k++) m[k] = 8'hFF;
      tv[0] = mk("rise_at_5", m, 99, 1, 0, 5);
      m = '0; for (int k = 0; k < 3; k++) m[k] = 8'hFF;
      for (int k = 10; k < NTAP; k++) m[k] = 8'hFF;
      tv[1] = mk("skip_high_rise_10", m, 99, 1, 0, 10);
      m = '0;
      tv[2] = mk("all_zero_fail", m, 99, 0, 1, NTAP - 1);
      tv[3] = mk("oor_at_4", m, 4, 0, 1, 4);
      m = '0; m[3] = 8'h0F; m[6] = 8'h1F; for (int k = 7; k < NTAP; k++) m[k] = 8'hFF;
      tv[4] = mk("tie_then_5of8", m, 99, 1, 0, 6);
      m = '0; m[0] = 8'h07; for (int k = 1; k < NTAP; k++) m[k] = 8'hFF;
      tv[5] = mk("rise_at_1", m, 99, 1, 0, 1);
      m = '1;
      tv[6] = mk("all_high_fail", m, 99, 0, 1, NTAP - 1);

      repeat (3) @(posedge FAB_CLK);
      #2;
      chk_idle_outputs("reset");
      @(negedge FAB_CLK); RESET_N = 1'b1;
      repeat (2) @(posedge FAB_CLK);
      #2;
      chk_idle_outputs("idle");

      for (int i = 0; i < 7; i++) run_case(tv[i]);

      // Reset pulse in the middle of tap 2's sample window.
      cur_mask = tv[0].mask; oor_tap = 99;
      @(negedge FAB_CLK); START = 1'b1;
      @(posedge FAB_CLK); #2; START = 1'b0;
      waited = 0;
      while (!(drv_tap == 2 && drv_off == SETTLE + 3) && waited < BUDGET) begin
         @(posedge FAB_CLK); #2; waited++;
      end
      chk("reach mid-sample", (waited < BUDGET), 1);
      @(negedge FAB_CLK); RESET_N = 1'b0;
      @(posedge FAB_CLK); #2;
      chk_idle_outputs("mid-sweep reset");
      @(negedge FAB_CLK); RESET_N = 1'b1;
      @(posedge FAB_CLK); #2;
      chk_idle_outputs("after reset");
      run_case(tv[0]);

      for (int r = 0; r < 20; r++) begin
         for (int k = 0; k < NTAP; k++) m[k] = 8'($urandom);
         model(m, d, e, t);
         run_case(mk($sformatf("rand%0d", r), m, 99, d, e, t));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
